method_call_driver: RTL and testbench

Synthesizable driver that issues method calls into a Synthesijer-generated module through its `<method>_req` / `<method>_busy` handshake. It accepts argument pairs on a valid/ready input stream, presents them on the method argument ports, runs the req/busy handshake, captures the return value, and emits it on a valid/ready output stream. It sits directly upstream of the generated module (e.g. Test000's `test` method) and replaces hand-written stimulus `always` blocks such as a counter-based req.

---
 rtl/method_call_driver.sv | 104 ++++++++++
 tb/tb_method_call_driver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/method_call_driver.sv
// method_call_driver: feeds argument pairs into a Synthesijer method via req/busy,
// captures the return value (or a timeout marker) and hands it downstream.
module method_call_driver #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] m_a,
    output logic [DATA_W-1:0] m_b,
    output logic              m_req,
    input  logic              m_busy,
    input  logic [DATA_W-1:0] m_return,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_timeout,
    output logic [CNT_W-1:0]  calls_done
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, OUTPUT} state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] m_a_q, m_b_q, out_data_q;
    logic              m_req_q, out_valid_q, out_timeout_q;
    logic [CNT_W-1:0]  calls_done_q;
    logic              expired;

    assign timer_d  = (&timer_q) ? timer_q : timer_q + TW'(1);
    assign expired  = timer_q == TW'(TIMEOUT - 1);
    // Ready is held low during reset and while the downstream module is still busy.
    assign in_ready = reset && state_q == IDLE && !m_busy;

    assign m_a         = m_a_q;
    assign m_b         = m_b_q;
    assign m_req       = m_req_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_timeout = out_timeout_q;
    assign calls_done  = calls_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            m_a_q         <= '0;
            m_b_q         <= '0;
            m_req_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_timeout_q <= 1'b0;
            calls_done_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready) begin
                    m_a_q   <= in_a;
                    m_b_q   <= in_b;
                    timer_q <= '0;
                    m_req_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: if (m_busy) begin
                    m_req_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT_DONE;
                end else if (expired) begin
                    m_req_q       <= 1'b0;
                    out_data_q    <= '0;
                    out_timeout_q <= 1'b1;
                    out_valid_q   <= 1'b1;
                    state_q       <= OUTPUT;
                end else begin
                    timer_q <= timer_d;
                end
                WAIT_DONE: if (!m_busy) begin
                    out_data_q    <= m_return;
                    out_timeout_q <= 1'b0;
                    out_valid_q   <= 1'b1;
                    state_q       <= OUTPUT;
                end else if (expired) begin
                    out_data_q    <= '0;
                    out_timeout_q <= 1'b1;
                    out_valid_q   <= 1'b1;
                    state_q       <= OUTPUT;
                end else begin
                    timer_q <= timer_d;
                end
                OUTPUT: if (out_ready) begin
                    out_valid_q  <= 1'b0;
                    calls_done_q <= calls_done_q + CNT_W'(1);
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_method_call_driver.sv
// tb_method_call_driver: drives calls into method_call_driver against a registered
// req/busy method model; expected results come from argument sums and timing rules.
module tb_method_call_driver;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0, reset = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          in_ready, m_req, m_busy, out_valid, out_timeout;
    logic [DW-1:0] m_a, m_b, m_return, out_data;
    logic [15:0]   calls_done;
    logic          in_ready2, m_req2, out_valid2, out_timeout2;
    logic [DW-1:0] m_a2, m_b2, out_data2;
    logic [1:0]    calls_done2;

    int errors = 0, checks = 0;
    int mode = 0, dur = 1, bcnt = 0, ncalls = 0, cyc = 0;
    int acc_q[$];
    logic [DW:0] out_q[$];

    always #5 clk = ~clk;

    method_call_driver #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .m_a(m_a), .m_b(m_b), .m_req(m_req),
        .m_busy(m_busy), .m_return(m_return), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_timeout(out_timeout),
        .calls_done(calls_done)
    );

    method_call_driver #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .m_a(m_a2), .m_b(m_b2), .m_req(m_req2),
        .m_busy(m_busy), .m_return(m_return), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_timeout(out_timeout2),
        .calls_done(calls_done2)
    );

    // Method model: sees req on a clock edge, stays busy for dur cycles, returns a+b.
    // mode 1 never raises busy.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   <= 1'b0;
            bcnt     <= 0;
            m_return <= '0;
        end else if (mode == 1) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (bcnt == 1) begin
                m_busy   <= 1'b0;
                m_return <= m_a + m_b;
            end
            bcnt <= bcnt - 1;
        end else if (m_req) begin
            m_busy   <= 1'b1;
            bcnt     <= dur;
            m_return <= $urandom;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) out_q.push_back({out_timeout, out_data});
    end

    task automatic do_call(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat,
                           output int reqs, output logic [DW-1:0] d, output logic to);
        int n = 0;
        lat = 0;
        reqs = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 60) begin
            if (m_req) reqs++;
            @(posedge clk); #1;
            lat++;
        end
        if (n >= 300 || lat >= 60) begin
            checks++; errors++;
            $display("FAIL call_wait: accept_wait=%0d result_wait=%0d exceeded bound", n, lat);
        end
        d = out_data;
        to = out_timeout;
    endtask

    task automatic consume(input int hold);
        out_ready = 1'b0;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ncalls++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if ({m_a, m_b, m_req, out_valid, out_data, out_timeout, calls_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: m_a=%0d m_b=%0d req=%b ov=%b od=%0d to=%b cd=%0d want all 0",
                     m_a, m_b, m_req, out_valid, out_data, out_timeout, calls_done);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        int base, ob, n;
        base = acc_q.size();
        ob = out_q.size();
        mode = 0;
        dur = 1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            in_a = DW'(i);
            in_b = DW'(2 * i);
            in_valid = 1'b1;
            while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (out_q.size() < ob + 5 && n < 100) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        ncalls += 5;
        checks++;
        if (out_q.size() != ob + 5) begin
            errors++;
            $display("FAIL stream_count: got %0d results want 5", out_q.size() - ob);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_q[ob + i] !== {1'b0, DW'(3 * i)}) begin
                    errors++;
                    $display("FAIL stream_result[%0d]: got %0h want %0h", i, out_q[ob + i], 3 * i);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_q[base + i + 1] - acc_q[base + i] != 5) begin
                errors++;
                $display("FAIL stream_period[%0d]: got %0d want 5", i, acc_q[base + i + 1] - acc_q[base + i]);
            end
        end
        checks++;
        if (calls_done !== 16'(ncalls) || calls_done2 !== 2'(ncalls)) begin
            errors++;
            $display("FAIL stream_calls_done: got %0d/%0d want %0d/%0d", calls_done, calls_done2, ncalls, ncalls % 4);
        end
    endtask

    task automatic test_basic();
        int lat, reqs;
        logic [DW-1:0] d;
        logic to;
        mode = 0;
        dur = 6;
        do_call(100, 3, lat, reqs, d, to);
        checks++;
        if (d !== 103 || to !== 1'b0) begin errors++; $display("FAIL basic_result: got %0d/%b want 103/0", d, to); end
        checks++;
        if (reqs != 2) begin errors++; $display("FAIL basic_req_cycles: got %0d want 2", reqs); end
        checks++;
        // req seen one edge late, busy 6 cycles, then one edge to capture: dur + 2 edges
        if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (m_a !== 100 || m_b !== 3) begin errors++; $display("FAIL basic_args: got %0d,%0d want 100,3", m_a, m_b); end
        consume(0);
        checks++;
        if (calls_done !== 16'(ncalls)) begin errors++; $display("FAIL basic_calls_done: got %0d want %0d", calls_done, ncalls); end
    endtask

    task automatic test_backpressure();
        int lat, reqs;
        logic [DW-1:0] d;
        logic to;
        dur = 1;
        do_call(100, 3, lat, reqs, d, to);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (!out_valid || out_data !== 103 || in_ready !== 1'b0 || calls_done !== 16'(ncalls)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b od=%0d ir=%b cd=%0d want 1/103/0/%0d",
                         i, out_valid, out_data, in_ready, calls_done, ncalls);
            end
        end
        consume(0);
        checks++;
        if (calls_done !== 16'(ncalls) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: cd=%0d ov=%b ir=%b want %0d/0/1", calls_done, out_valid, in_ready, ncalls);
        end
    endtask

    task automatic test_timeout_rise();
        int lat, reqs;
        logic [DW-1:0] d;
        logic to;
        mode = 1;
        do_call(7, 9, lat, reqs, d, to);
        checks++;
        if (d !== 0 || to !== 1'b1) begin errors++; $display("FAIL rise_to_result: got %0d/%b want 0/1", d, to); end
        checks++;
        if (reqs != TO || lat != TO) begin errors++; $display("FAIL rise_to_timing: req=%0d lat=%0d want %0d", reqs, lat, TO); end
        consume(1);
        checks++;
        if (m_req !== 1'b0 || calls_done !== 16'(ncalls)) begin
            errors++;
            $display("FAIL rise_to_after: req=%b cd=%0d want 0/%0d", m_req, calls_done, ncalls);
        end
        mode = 0;
    endtask

    task automatic test_stuck_busy();
        int lat, reqs, n;
        logic [DW-1:0] d;
        logic to;
        dur = 100;
        do_call(5, 6, lat, reqs, d, to);
        checks++;
        if (d !== 0 || to !== 1'b1) begin errors++; $display("FAIL stuck_result: got %0d/%b want 0/1", d, to); end
        checks++;
        if (lat != TO + 2) begin errors++; $display("FAIL stuck_latency: got %0d want %0d", lat, TO + 2); end
        consume(0);
        checks++;
        if (in_ready !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck_ready_low: ir=%b busy=%b want 0/1", in_ready, m_busy);
        end
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_ready_after: ir=%b busy=%b want 1/0", in_ready, m_busy);
        end
    endtask

    task automatic test_random();
        int lat, reqs;
        logic [DW-1:0] a, b, d;
        logic to;
        mode = 0;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            dur = $urandom_range(1, 4);
            do_call(a, b, lat, reqs, d, to);
            checks++;
            if (d !== a + b || to !== 1'b0 || lat != dur + 2) begin
                errors++;
                $display("FAIL random[%0d]: got %0h/%b lat=%0d want %0h/0 lat=%0d", i, d, to, lat, a + b, dur + 2);
            end
            consume($urandom_range(0, 3));
            checks++;
            if (calls_done !== 16'(ncalls) || calls_done2 !== 2'(ncalls)) begin
                errors++;
                $display("FAIL random_cd[%0d]: got %0d/%0d want %0d/%0d", i, calls_done, calls_done2, ncalls, ncalls % 4);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat, reqs, n;
        logic [DW-1:0] d;
        logic to;
        mode = 0;
        dur = 20;
        n = 0;
        in_a = 11;
        in_b = 22;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #3 reset = 1'b0;
        #1;
        ncalls = 0;
        checks++;
        if ({in_ready, m_a, m_b, m_req, out_valid, out_data, out_timeout, calls_done, calls_done2} !== '0) begin
            errors++;
            $display("FAIL async_reset: ir=%b m_a=%0d m_b=%0d req=%b ov=%b od=%0d to=%b cd=%0d want all 0",
                     in_ready, m_a, m_b, m_req, out_valid, out_data, out_timeout, calls_done);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        dur = 2;
        do_call(40, 2, lat, reqs, d, to);
        checks++;
        if (d !== 42 || to !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL post_reset_call: got %0d/%b lat=%0d want 42/0 lat=4", d, to, lat);
        end
        consume(0);
        checks++;
        if (calls_done !== 16'd1 || calls_done2 !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_cd: got %0d/%0d want 1/1", calls_done, calls_done2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_basic();
        test_backpressure();
        test_timeout_rise();
        test_stuck_busy();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
